// File: rtl/k12a_sequencer.sv
// rtl/k12a_sequencer.sv - K12A control unit state, instruction and skip registers with wake conditioning (optional K12A_SINGLE_STEP_EN)
package k12a_pkg;
    typedef logic [2:0] state_t;
    localparam logic [2:0] STATE_FETCH1 = 3'd0;
    localparam logic [2:0] STATE_FETCH2 = 3'd1;
    localparam logic [2:0] STATE_FETCH3 = 3'd2;
    localparam logic [2:0] STATE_EXEC   = 3'd3;
    localparam logic [2:0] STATE_POP    = 3'd4;
    localparam logic [2:0] STATE_RJMP   = 3'd5;
    localparam logic [2:0] STATE_HALT   = 3'd6;

    typedef logic [1:0] skip_sel_t;
    localparam logic [1:0] SKIP_SEL_0                  = 2'd0;
    localparam logic [1:0] SKIP_SEL_CONDITION          = 2'd1;
    localparam logic [1:0] SKIP_SEL_CONDITION_INVERTED = 2'd2;
endpackage

module k12a_sequencer
    import k12a_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int INSTRET_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  state_t                   next_state,
    input  logic                     inst_high_store,
    input  logic                     inst_low_store,
    input  logic                     skip_store,
    input  skip_sel_t                skip_sel,
    input  logic                     alu_condition,
    input  logic [7:0]               data_bus,
    input  logic                     wake_request,
`ifdef K12A_SINGLE_STEP_EN
    input  logic                     step_mode,
    output logic                     step_done,
`endif
    output state_t                   state,
    output logic [15:0]              inst,
    output logic                     skip,
    output logic                     wake,
    output logic                     halted,
    output logic [INSTRET_WIDTH-1:0] instret
);

    logic [SYNC_STAGES-1:0] wake_sync;
    logic                   wake_hist;
    logic                   wake_edge;
    logic                   skip_next;
    state_t                 state_next;

`ifdef K12A_SINGLE_STEP_EN
    logic step_override;

    // Retiring an instruction while stepping parks the core in HALT instead of fetching.
    always_comb begin
        step_override = step_mode && (next_state == STATE_FETCH1) &&
                        ((state == STATE_EXEC) || (state == STATE_POP) || (state == STATE_RJMP));
        state_next    = step_override ? STATE_HALT : next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_done <= 1'b0;
        end else begin
            step_done <= step_override;
        end
    end
`else
    assign state_next = next_state;
`endif

    assign wake_edge = wake_sync[SYNC_STAGES-1] & ~wake_hist;

    always_comb begin
        skip_next = 1'b0;
        case (skip_sel)
            SKIP_SEL_CONDITION:          skip_next = alu_condition;
            SKIP_SEL_CONDITION_INVERTED: skip_next = ~alu_condition;
            default:                     skip_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= STATE_FETCH1;
            halted    <= 1'b0;
            inst      <= 16'h0000;
            skip      <= 1'b0;
            wake      <= 1'b0;
            wake_sync <= '0;
            wake_hist <= 1'b0;
            instret   <= '0;
        end else begin
            state     <= state_next;
            halted    <= (state_next == STATE_HALT);
            if (inst_high_store) begin
                inst[15:8] <= data_bus;
            end
            if (inst_low_store) begin
                inst[7:0] <= data_bus;
            end
            if (skip_store) begin
                skip <= skip_next;
            end
            wake_sync <= {wake_sync[SYNC_STAGES-2:0], wake_request};
            wake_hist <= wake_sync[SYNC_STAGES-1];
            // Edges seen outside HALT are dropped; the pending wake drops as soon as HALT is left.
            wake      <= (state == STATE_HALT) && (state_next == STATE_HALT) && (wake | wake_edge);
            if (state == STATE_EXEC) begin
                instret <= instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
